// File: rtl/priority_index_decoder.sv
// rtl/priority_index_decoder.sv - rebuilds a bit mask from a priority-encoded index stream (optional checks: PRIO_INDEX_DECODER_ASSERT_EN)
module priority_index_decoder #(
  parameter int OUTPUT_WIDTH = 8,
  parameter int IDX_W        = $clog2(OUTPUT_WIDTH),
  parameter int CNT_W        = $clog2(OUTPUT_WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IDX_W-1:0]        in_index,
  input  logic                    in_last,
  input  logic                    in_empty,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] out_bits,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_err_order,
  output logic                    out_err_range
);

  typedef enum logic {S_FIRST, S_MID} state_t;

  localparam logic [OUTPUT_WIDTH-1:0] BIT0 = {{(OUTPUT_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [OUTPUT_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        prev_idx_q, prev_idx_d;
  logic                    prev_valid_q, prev_valid_d;
  logic                    err_order_q, err_order_d;
  logic                    err_range_q, err_range_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUTPUT_WIDTH-1:0] out_bits_q, out_bits_d;
  logic [CNT_W-1:0]        out_count_q, out_count_d;
  logic                    out_err_order_q, out_err_order_d;
  logic                    out_err_range_q, out_err_range_d;

  logic                    accept;
  logic                    in_range;
  logic                    is_idx;
  logic                    new_bit;
  logic [OUTPUT_WIDTH-1:0] onehot;
  logic [OUTPUT_WIDTH-1:0] frame_acc;
  logic [CNT_W-1:0]        frame_cnt;
  logic                    frame_ord;
  logic                    frame_rng;

  // A stalled output stalls the whole input, since the ready is shared.
  assign in_ready      = !out_valid_q || out_ready;
  assign out_valid     = out_valid_q;
  assign out_bits      = out_bits_q;
  assign out_count     = out_count_q;
  assign out_err_order = out_err_order_q;
  assign out_err_range = out_err_range_q;

  // Fold the current beat into the frame and decide what the next cycle holds.
  always_comb begin
    accept    = in_valid && in_ready;
    in_range  = 32'(in_index) < OUTPUT_WIDTH;
    is_idx    = !in_empty && in_range;
    onehot    = BIT0 << in_index;
    new_bit   = is_idx && !(|(acc_q & onehot));
    frame_acc = is_idx ? (acc_q | onehot) : acc_q;
    frame_cnt = cnt_q + {{(CNT_W-1){1'b0}}, new_bit};
    // The tracker only holds in-range indices, so empty or dropped beats never
    // serve as the reference for the ordering check.
    frame_ord = err_order_q ||
                (is_idx && state_q == S_MID && prev_valid_q && in_index <= prev_idx_q);
    frame_rng = err_range_q || (!in_empty && !in_range);

    state_d         = state_q;
    acc_d           = acc_q;
    cnt_d           = cnt_q;
    prev_idx_d      = prev_idx_q;
    prev_valid_d    = prev_valid_q;
    err_order_d     = err_order_q;
    err_range_d     = err_range_q;
    out_valid_d     = out_valid_q;
    out_bits_d      = out_bits_q;
    out_count_d     = out_count_q;
    out_err_order_d = out_err_order_q;
    out_err_range_d = out_err_range_q;

    if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (in_last) begin
        out_valid_d     = 1'b1;
        out_bits_d      = frame_acc;
        out_count_d     = frame_cnt;
        out_err_order_d = frame_ord;
        out_err_range_d = frame_rng;
        state_d         = S_FIRST;
        acc_d           = '0;
        cnt_d           = '0;
        prev_idx_d      = '0;
        prev_valid_d    = 1'b0;
        err_order_d     = 1'b0;
        err_range_d     = 1'b0;
      end else begin
        state_d     = S_MID;
        acc_d       = frame_acc;
        cnt_d       = frame_cnt;
        err_order_d = frame_ord;
        err_range_d = frame_rng;
        if (is_idx) begin
          prev_idx_d   = in_index;
          prev_valid_d = 1'b1;
        end
      end
    end
  end

  // Register the frame accumulator and output stage; reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_FIRST;
      acc_q           <= '0;
      cnt_q           <= '0;
      prev_idx_q      <= '0;
      prev_valid_q    <= 1'b0;
      err_order_q     <= 1'b0;
      err_range_q     <= 1'b0;
      out_valid_q     <= 1'b0;
      out_bits_q      <= '0;
      out_count_q     <= '0;
      out_err_order_q <= 1'b0;
      out_err_range_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      cnt_q           <= cnt_d;
      prev_idx_q      <= prev_idx_d;
      prev_valid_q    <= prev_valid_d;
      err_order_q     <= err_order_d;
      err_range_q     <= err_range_d;
      out_valid_q     <= out_valid_d;
      out_bits_q      <= out_bits_d;
      out_count_q     <= out_count_d;
      out_err_order_q <= out_err_order_d;
      out_err_range_q <= out_err_range_d;
    end
  end

`ifdef PRIO_INDEX_DECODER_ASSERT_EN
  logic                    hold_q;
  logic [OUTPUT_WIDTH-1:0] held_bits_q;

  // Self-consistency checks on the output stage and the incoming index.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (out_valid_q) begin
        assert (out_count_q == CNT_W'($countones(out_bits_q)));
      end
      if (in_valid && !in_empty) begin
        assert (!$isunknown(in_index));
      end
      if (hold_q) begin
        assert (out_bits_q == held_bits_q);
      end
    end
    hold_q      <= rst_n && out_valid_q && !out_ready;
    held_bits_q <= out_bits_q;
  end
`else
  // Checks not compiled in this build.
`endif

endmodule

// File: tb/tb_priority_index_decoder.sv
// tb/tb_priority_index_decoder.sv - directed vector bench for priority_index_decoder
module tb_priority_index_decoder;

  typedef struct {
    logic [2:0] idx;
    logic       last;
    logic       empty;
    logic [7:0] bits;
    logic [3:0] cnt;
    logic       ord;
    logic       rng;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  logic       a_in_valid, a_in_ready, a_in_last, a_in_empty;
  logic [2:0] a_in_index;
  logic       a_out_valid, a_out_ready, a_err_order, a_err_range;
  logic [7:0] a_out_bits;
  logic [3:0] a_out_count;

  logic       b_in_valid, b_in_ready, b_in_last, b_in_empty;
  logic [2:0] b_in_index;
  logic       b_out_valid, b_out_ready, b_err_order, b_err_range;
  logic [4:0] b_out_bits;
  logic [2:0] b_out_count;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  priority_index_decoder #(.OUTPUT_WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_index(a_in_index),
    .in_last(a_in_last), .in_empty(a_in_empty),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_bits(a_out_bits),
    .out_count(a_out_count), .out_err_order(a_err_order), .out_err_range(a_err_range)
  );

  priority_index_decoder #(.OUTPUT_WIDTH(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_index(b_in_index),
    .in_last(b_in_last), .in_empty(b_in_empty),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_bits(b_out_bits),
    .out_count(b_out_count), .out_err_order(b_err_order), .out_err_range(b_err_range)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] idx, input logic last, input logic empty,
                     input logic [7:0] bits, input logic [3:0] cnt,
                     input logic ord, input logic rng);
    vec_t v;
    v.idx = idx; v.last = last; v.empty = empty;
    v.bits = bits; v.cnt = cnt; v.ord = ord; v.rng = rng;
    vecs.push_back(v);
  endtask

  task automatic beat8(input logic [2:0] idx, input logic last, input logic empty);
    a_in_valid = 1'b1; a_in_index = idx; a_in_last = last; a_in_empty = empty;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic beat5(input logic [2:0] idx, input logic last);
    b_in_valid = 1'b1; b_in_index = idx; b_in_last = last; b_in_empty = 1'b0;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // idx last empty bits cnt ord rng (bits/cnt/flags only checked on last beats)
    add(3'd1, 0, 0, 8'h00, 4'd0, 0, 0);
    add(3'd4, 0, 0, 8'h00, 4'd0, 0, 0);
    add(3'd6, 1, 0, 8'h52, 4'd3, 0, 0);
    add(3'd0, 1, 1, 8'h00, 4'd0, 0, 0);
    add(3'd5, 0, 0, 8'h00, 4'd0, 0, 0);
    add(3'd2, 1, 0, 8'h24, 4'd2, 1, 0);
    add(3'd3, 0, 0, 8'h00, 4'd0, 0, 0);
    add(3'd3, 1, 0, 8'h08, 4'd1, 1, 0);
    add(3'd0, 0, 0, 8'h00, 4'd0, 0, 0);
    add(3'd7, 1, 0, 8'h81, 4'd2, 0, 0);
    add(3'd2, 0, 0, 8'h00, 4'd0, 0, 0);
    add(3'd1, 0, 1, 8'h00, 4'd0, 0, 0);
    add(3'd5, 1, 0, 8'h24, 4'd2, 0, 0);
    for (int i = 0; i < 8; i++) begin
      add(3'(i), (i == 7), 0, 8'hFF, 4'd8, 0, 0);
    end

    rst_n = 1'b0;
    a_in_valid = 0; a_in_index = 0; a_in_last = 0; a_in_empty = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_index = 0; b_in_last = 0; b_in_empty = 0; b_out_ready = 1;
    @(posedge clk); #1;
    check("reset_in_ready", a_in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("reset_out_valid", a_out_valid, 0);
    check("reset_out_bits", a_out_bits, 0);
    check("reset_out_count", a_out_count, 0);
    check("reset_err_order", a_err_order, 0);
    check("reset_err_range", a_err_range, 0);
    check("reset_in_ready_after", a_in_ready, 1);

    foreach (vecs[i]) begin
      beat8(vecs[i].idx, vecs[i].last, vecs[i].empty);
      check($sformatf("vec%0d_valid", i), a_out_valid, vecs[i].last);
      if (vecs[i].last) begin
        check($sformatf("vec%0d_bits", i), a_out_bits, vecs[i].bits);
        check($sformatf("vec%0d_count", i), a_out_count, vecs[i].cnt);
        check($sformatf("vec%0d_order", i), a_err_order, vecs[i].ord);
        check($sformatf("vec%0d_range", i), a_err_range, vecs[i].rng);
      end
    end
    @(posedge clk); #1;
    check("idle_valid_low", a_out_valid, 0);

    // Range error on the 5-bit instance: index 6 is dropped.
    beat5(3'd0, 0);
    check("w5_mid_valid", b_out_valid, 0);
    beat5(3'd6, 1);
    check("w5_valid", b_out_valid, 1);
    check("w5_bits", b_out_bits, 5'b00001);
    check("w5_count", b_out_count, 1);
    check("w5_range", b_err_range, 1);
    check("w5_order", b_err_order, 0);

    // Output stall then back-to-back single-beat frames.
    a_out_ready = 1'b0;
    a_in_valid = 1; a_in_index = 3'd7; a_in_last = 1; a_in_empty = 0;
    @(posedge clk); #1;
    check("stall_valid", a_out_valid, 1);
    check("stall_bits0", a_out_bits, 8'h80);
    a_in_index = 3'd0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("stall_in_ready%0d", c), a_in_ready, 0);
      @(posedge clk); #1;
      check($sformatf("stall_bits%0d", c + 1), a_out_bits, 8'h80);
      check($sformatf("stall_hold_valid%0d", c), a_out_valid, 1);
    end
    a_out_ready = 1'b1;
    #1;
    check("release_in_ready", a_in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      a_in_index = 3'(k);
      @(posedge clk); #1;
      check($sformatf("b2b_valid%0d", k), a_out_valid, 1);
      check($sformatf("b2b_bits%0d", k), a_out_bits, 8'h01 << k);
      check($sformatf("b2b_count%0d", k), a_out_count, 1);
    end
    a_in_valid = 0; a_in_last = 0;
    @(posedge clk); #1;
    check("b2b_drain_valid", a_out_valid, 0);

    // Reset in the middle of a frame discards the partial mask.
    beat8(3'd2, 0, 0);
    beat8(3'd3, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_valid", a_out_valid, 0);
    check("midrst_in_ready", a_in_ready, 1);
    rst_n = 1'b1;
    beat8(3'd0, 1, 0);
    check("midrst_frame_valid", a_out_valid, 1);
    check("midrst_frame_bits", a_out_bits, 8'h01);
    check("midrst_frame_count", a_out_count, 1);
    check("midrst_frame_order", a_err_order, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
